rex_game_core: RTL and testbench

//  Game-logic stage feeding the frame renderer (Decider): replaces the hardwired
//  rex_down / obstacle_left / game_state debug constants with live values.

---
 rtl/rex_pkg.sv | 25 ++
 rtl/rex_btn_sync.sv | 28 ++
 rtl/rex_game_core.sv | 155 +++++++++++++++
 tb/tb_rex_game_core.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rex_pkg.sv
// Shared game constants: state encodings and sprite geometry, common with the Decider.
package rex_pkg;

  // Encodings match the Decider's game_state input.
  typedef enum logic [1:0] {
    GS_PLAY  = 2'b00,
    GS_READY = 2'b01,
    GS_OVER  = 2'b10
  } game_state_t;

  localparam logic [15:0]        SCREEN_W  = 16'd128;
  localparam logic [15:0]        REX_X     = 16'd8;
  localparam logic [15:0]        REX_W     = 16'd16;
  localparam logic [15:0]        OBS_W     = 16'd8;
  localparam logic [15:0]        OBS_H     = 16'd12;
  localparam logic [15:0]        OBS_SPEED = 16'd2;
  localparam logic signed [7:0]  JUMP_V    = 8'sd7;
  localparam logic [7:0]         LFSR_SEED = 8'hA5;

  // One step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR, shifting toward the MSB.
  function automatic logic [7:0] lfsrNext(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/rex_btn_sync.sv
// Brings the raw jump button into the clock domain and emits a one-cycle pulse on each rising edge.
module rex_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Two-flop synchroniser followed by a delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_press = r_sync & ~r_prev;

endmodule

// File: rtl/rex_game_core.sv
// Game logic for the rex runner: frame tick, READY/PLAY/OVER flow, jump physics,
// obstacle scrolling, collision and score, all advancing once per frame tick.
module rex_game_core
  import rex_pkg::*;
#(
  parameter int TICK_DIV = 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_i,
  output logic [15:0] rex_down_o,
  output logic [15:0] obstacle_left_o,
  output logic [1:0]  game_state_o,
  output logic [15:0] score_o,
  output logic        tick_o
);

  localparam int              CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [15:0]     REX_RIGHT = REX_X + REX_W;

  logic [CW-1:0]      r_cnt;
  logic               r_tick;
  logic [CW-1:0]      w_cntNext;
  logic [7:0]         r_lfsr;
  game_state_t        r_state;
  logic [15:0]        r_rexDown;
  logic signed [7:0]  r_vel;
  logic [15:0]        r_obsLeft;
  logic [15:0]        r_score;
  logic               r_pend;

  logic               w_press;
  logic               w_pendEff;
  logic signed [17:0] w_sum;
  logic [15:0]        w_hNext;
  logic signed [7:0]  w_vNext;
  logic [15:0]        w_olNext;
  logic [15:0]        w_scoreNext;
  logic               w_hit;

  rex_btn_sync u_btn (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (jump_i),
    .o_press (w_press)
  );

  assign w_cntNext = r_tick ? '0 : r_cnt + CW'(1);

  // Free-running frame divider; r_tick is high exactly while the counter sits at its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cntNext;
      r_tick <= (w_cntNext == CNT_LAST);
    end
  end

  // Pseudo-random source for obstacle respawn offsets, stepping every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsrNext(r_lfsr);
    end
  end

  // A press only arms a jump while the rex is standing still on the ground.
  assign w_pendEff = r_pend | (w_press && (r_rexDown == 16'd0) && (r_vel == 8'sd0));

  // Next-frame positions, score and collision, evaluated on the values the tick will register.
  always_comb begin
    w_sum       = $signed({2'b00, r_rexDown}) + $signed({{10{r_vel[7]}}, r_vel});
    w_hNext     = r_rexDown;
    w_vNext     = r_vel;
    w_olNext    = r_obsLeft - OBS_SPEED;
    w_scoreNext = r_score;
    if (w_pendEff) begin
      w_hNext = {8'd0, JUMP_V};
      w_vNext = JUMP_V - 8'sd1;
    end else if ((r_rexDown != 16'd0) || (r_vel != 8'sd0)) begin
      if (w_sum <= 18'sd0) begin
        w_hNext = 16'd0;
        w_vNext = 8'sd0;
      end else begin
        w_hNext = w_sum[15:0];
        w_vNext = r_vel - 8'sd1;
      end
    end
    if (r_obsLeft < OBS_SPEED) begin
      w_olNext    = SCREEN_W + {11'd0, r_lfsr[4:0]};
      w_scoreNext = (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;
    end
    w_hit = (w_olNext < REX_RIGHT) &&
            (({1'b0, w_olNext} + {1'b0, OBS_W}) > {1'b0, REX_X}) &&
            (w_hNext < OBS_H);
  end

  // Game state machine; in PLAY a tick commits the physics step, and a hit freezes the picture in OVER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= GS_READY;
      r_rexDown <= 16'd0;
      r_vel     <= 8'sd0;
      r_obsLeft <= SCREEN_W;
      r_score   <= 16'd0;
      r_pend    <= 1'b0;
    end else begin
      case (r_state)
        GS_READY: begin
          if (w_press) begin
            r_state   <= GS_PLAY;
            r_rexDown <= 16'd0;
            r_vel     <= 8'sd0;
            r_obsLeft <= SCREEN_W;
            r_score   <= 16'd0;
            r_pend    <= 1'b0;
          end
        end
        GS_PLAY: begin
          if (r_tick) begin
            r_rexDown <= w_hNext;
            r_vel     <= w_vNext;
            r_obsLeft <= w_olNext;
            r_score   <= w_scoreNext;
            r_pend    <= 1'b0;
            if (w_hit) begin
              r_state <= GS_OVER;
            end
          end else begin
            r_pend <= w_pendEff;
          end
        end
        GS_OVER: begin
          if (w_press) begin
            r_state <= GS_READY;
          end
        end
        default: begin
          r_state <= GS_READY;
        end
      endcase
    end
  end

  assign rex_down_o      = r_rexDown;
  assign obstacle_left_o = r_obsLeft;
  assign game_state_o    = r_state;
  assign score_o         = r_score;
  assign tick_o          = r_tick;

endmodule

// File: tb/tb_rex_game_core.sv
// Self-checking bench for rex_game_core: a frame-level game model checked every cycle,
// plus directed scenarios with hand-computed positions, heights and states.
module tb_rex_game_core;

  localparam int TICK_DIV = 4;
  localparam int S_PLAY = 0, S_READY = 1, S_OVER = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_i = 1'b0;
  logic [15:0] rex_down_o;
  logic [15:0] obstacle_left_o;
  logic [1:0]  game_state_o;
  logic [15:0] score_o;
  logic        tick_o;

  int total = 0;
  int bad = 0;

  // Frame-level model of the game
  int mState, mH, mV, mOl, mScore, mCnt, mLfsr;
  bit mPend;
  bit hist [3];

  rex_game_core #(.TICK_DIV(TICK_DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .jump_i          (jump_i),
    .rex_down_o      (rex_down_o),
    .obstacle_left_o (obstacle_left_o),
    .game_state_o    (game_state_o),
    .score_o         (score_o),
    .tick_o          (tick_o)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its required value
  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    total++;
    if (actual !== expected[31:0]) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic level);
    jump_i = level;
  endtask

  // Game rules advanced once per clock edge, from the button history and frame count
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mState = S_READY; mH = 0; mV = 0; mOl = 128; mScore = 0;
      mCnt = 0; mLfsr = 8'hA5; mPend = 0;
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
    end else begin
      bit press, tick;
      int s;
      press = hist[1] && !hist[2];
      tick  = (mCnt == TICK_DIV - 1);
      if (mState == S_READY) begin
        if (press) begin
          mState = S_PLAY; mH = 0; mV = 0; mOl = 128; mScore = 0; mPend = 0;
        end
      end else if (mState == S_OVER) begin
        if (press) mState = S_READY;
      end else begin
        if (press && mH == 0 && mV == 0) mPend = 1;
        if (tick) begin
          if (mPend) begin
            mH = 7; mV = 6; mPend = 0;
          end else if (mH != 0 || mV != 0) begin
            s = mH + mV;
            if (s <= 0) begin mH = 0; mV = 0; end
            else begin mH = s; mV = mV - 1; end
          end
          if (mOl < 2) begin
            mOl = 128 + (mLfsr % 32);
            if (mScore < 65535) mScore = mScore + 1;
          end else begin
            mOl = mOl - 2;
          end
          if (mOl < 24 && mOl + 8 > 8 && mH < 12) mState = S_OVER;
        end
      end
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = jump_i;
      mCnt = (mCnt + 1) % TICK_DIV;
      mLfsr = ((mLfsr << 1) | (((mLfsr >> 7) ^ (mLfsr >> 5) ^ (mLfsr >> 4) ^ (mLfsr >> 3)) & 1)) & 255;
    end
  end

  // Every cycle out of reset, the DUT outputs must equal the model
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("model state", game_state_o, mState);
      checkOutput("model rex_down", rex_down_o, mH);
      checkOutput("model obstacle_left", obstacle_left_o, mOl);
      checkOutput("model score", score_o, mScore);
      checkOutput("model tick", tick_o, (mCnt == TICK_DIV - 1) ? 1 : 0);
    end
  end

  // Advance to the negedge after the next tick has been committed
  task automatic waitTick();
    int n = 0;
    while (tick_o !== 1'b1 && n < 3 * TICK_DIV) begin
      @(negedge clk);
      n++;
    end
    if (tick_o !== 1'b1) begin
      total++; bad++;
      $display("[TB] FAIL tick timeout: got no tick, required one within %0d cycles", 3 * TICK_DIV);
    end
    @(negedge clk);
  endtask

  // Reset, then press so that the first game tick is the next tick after the press
  task automatic startGame();
    int n = 0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("ready after reset", game_state_o, S_READY);
    while (tick_o !== 1'b1 && n < 3 * TICK_DIV) begin
      @(negedge clk);
      n++;
    end
    applyStimulus(1'b1);
    @(negedge clk);
    applyStimulus(1'b0);
  endtask

  // Raise the button and stay until the press has been acted on
  task automatic pressButton();
    applyStimulus(1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic releaseButton();
    applyStimulus(1'b0);
    repeat (2) @(negedge clk);
  endtask

  int heights [16] = '{0, 7, 13, 18, 22, 25, 27, 28, 28, 27, 25, 22, 18, 13, 7, 0};

  initial begin
    // Standing rex runs into the first obstacle
    startGame();
    waitTick();
    checkOutput("play after start", game_state_o, S_PLAY);
    checkOutput("ol after tick 1", obstacle_left_o, 126);
    repeat (51) waitTick();
    checkOutput("still play at tick 52", game_state_o, S_PLAY);
    checkOutput("ol at tick 52", obstacle_left_o, 24);
    waitTick();
    checkOutput("over at tick 53", game_state_o, S_OVER);
    checkOutput("ol at tick 53", obstacle_left_o, 22);
    checkOutput("rex at tick 53", rex_down_o, 0);
    checkOutput("score at tick 53", score_o, 0);
    repeat (2) waitTick();
    checkOutput("ol frozen in over", obstacle_left_o, 22);

    // OVER -> READY keeps the picture, READY -> PLAY starts afresh
    pressButton();
    checkOutput("ready after over", game_state_o, S_READY);
    checkOutput("ol kept in ready", obstacle_left_o, 22);
    releaseButton();
    pressButton();
    checkOutput("play after ready", game_state_o, S_PLAY);
    checkOutput("ol on restart", obstacle_left_o, 128);
    checkOutput("score on restart", score_o, 0);
    releaseButton();

    // Jump height profile, with a press mid-flight that must be ignored
    startGame();
    repeat (2) waitTick();
    applyStimulus(1'b1);
    @(negedge clk);
    applyStimulus(1'b0);
    for (int k = 1; k <= 15; k++) begin
      if (k == 5) applyStimulus(1'b1);
      if (k == 6) applyStimulus(1'b0);
      waitTick();
      checkOutput($sformatf("jump height %0d", k), rex_down_o, heights[k]);
    end

    // Jump timed to clear the obstacle, then respawn with score 1
    startGame();
    repeat (50) waitTick();
    checkOutput("ol before clearing jump", obstacle_left_o, 28);
    applyStimulus(1'b1);
    @(negedge clk);
    applyStimulus(1'b0);
    for (int k = 51; k <= 64; k++) begin
      waitTick();
      if (k == 57) checkOutput("rex over obstacle", rex_down_o, 28);
    end
    checkOutput("survived obstacle", game_state_o, S_PLAY);
    checkOutput("ol at tick 64", obstacle_left_o, 0);
    waitTick();
    checkOutput("score after clear", score_o, 1);
    checkOutput("ol respawn range", (obstacle_left_o >= 128 && obstacle_left_o <= 159) ? 1 : 0, 1);

    // Bounce: two presses two cycles apart give a single jump
    startGame();
    waitTick();
    applyStimulus(1'b1); @(negedge clk);
    applyStimulus(1'b0); @(negedge clk);
    applyStimulus(1'b1); @(negedge clk);
    applyStimulus(1'b0);
    waitTick();
    checkOutput("bounce first height", rex_down_o, 7);
    repeat (14) waitTick();
    checkOutput("bounce landed", rex_down_o, 0);
    waitTick();
    checkOutput("bounce no second jump", rex_down_o, 0);

    // Glitch between clock edges in READY is never sampled
    startGame();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 applyStimulus(1'b1);
    #2 applyStimulus(1'b0);
    repeat (5) @(negedge clk);
    checkOutput("glitch ignored", game_state_o, S_READY);

    // Random play with an asynchronous reset landing mid-cycle
    for (int run = 0; run < 6; run++) begin
      int len;
      startGame();
      len = 400 + $urandom_range(0, 300);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 99) < 15) applyStimulus(~jump_i);
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async reset state", game_state_o, S_READY);
      checkOutput("async reset rex", rex_down_o, 0);
      checkOutput("async reset ol", obstacle_left_o, 128);
      checkOutput("async reset score", score_o, 0);
      @(negedge clk);
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
